fetch_stage: RTL and testbench

Instruction fetch stage of the RV32i five-stage pipeline, directly upstream of decode. Holds the PC and issues single-outstanding requests to a variable-latency instruction memory. Applies execute-stage redirects and hazard-unit stall/flush. Drives the IF/ID pipeline register that feeds `Instr_D` to decode, inserting NOP bubbles whenever no valid instruction is available.

---
 rtl/fetch_stage_pkg.sv | 21 ++
 rtl/fetch_stage_if_id_register.sv | 53 +++++
 rtl/fetch_stage.sv | 182 ++++++++++++++++++
 tb/tb_fetch_stage.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the RV32i fetch stage: FSM state type, the
// bubble instruction, the default reset vector and a word-align helper.
package definitions;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY  = 2'd1,
        HOLD  = 2'd2,
        DRAIN = 2'd3
    } fetch_state_t;

    // addi x0, x0, 0
    localparam logic [31:0] INSTR_NOP            = 32'h0000_0013;
    localparam logic [31:0] RESET_VECTOR_DEFAULT = 32'h0000_0000;

    // Clears the two low address bits so every fetch is word aligned.
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/fetch_stage_if_id_register.sv
// IF/ID pipeline register. Priority: reset > bubble (redirect/flush) >
// hold (stall) > load of a fetched instruction > bubble. A bubble writes
// the NOP and clears valid but keeps the previous PC values.
module if_id_register
    import definitions::*;
(
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_bubble,
    input  logic        i_hold,
    input  logic        i_load,
    input  logic [31:0] i_instr,
    input  logic [31:0] i_pc,
    output logic [31:0] o_instr,
    output logic [31:0] o_pc,
    output logic [31:0] o_pc_plus_4,
    output logic        o_valid
);

    logic [31:0] r_instr;
    logic [31:0] r_pc;
    logic [31:0] r_pc_plus_4;
    logic        r_valid;

    // Pipeline register update: bubble, hold or load.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_instr     <= INSTR_NOP;
            r_pc        <= 32'd0;
            r_pc_plus_4 <= 32'd0;
            r_valid     <= 1'b0;
        end else if (i_bubble) begin
            r_instr <= INSTR_NOP;
            r_valid <= 1'b0;
        end else if (!i_hold) begin
            if (i_load) begin
                r_instr     <= i_instr;
                r_pc        <= i_pc;
                r_pc_plus_4 <= i_pc + 32'd4;
                r_valid     <= 1'b1;
            end else begin
                r_instr <= INSTR_NOP;
                r_valid <= 1'b0;
            end
        end
    end

    assign o_instr     = r_instr;
    assign o_pc        = r_pc;
    assign o_pc_plus_4 = r_pc_plus_4;
    assign o_valid     = r_valid;

endmodule

// File: rtl/fetch_stage.sv
// RV32i instruction fetch stage with a single outstanding request to a
// variable-latency instruction memory.
// Handshake: IMEM_Req/IMEM_Addr rise together and stay stable until the
// cycle in which IMEM_Req && IMEM_Ack, which completes the transfer; a
// redirect never alters an in-flight address (the reply is drained).
// Optional macro FETCH_PERF_EN adds Fetch_Count and Bubble_Count ports.
module fetch_stage
    import definitions::*;
#(
    parameter logic [31:0] RESET_VECTOR = RESET_VECTOR_DEFAULT
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        Stall_D,
    input  logic        Flush_D,
    input  logic        PC_Src_E,
    input  logic [31:0] PC_Target_E,
    output logic        IMEM_Req,
    output logic [31:0] IMEM_Addr,
    input  logic        IMEM_Ack,
    input  logic [31:0] IMEM_R_Data,
    output logic [31:0] Instr_D,
    output logic [31:0] PC_D,
    output logic [31:0] PC_Plus_4_D,
    output logic        Valid_D
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0] Fetch_Count,
    output logic [31:0] Bubble_Count
`endif
);

    fetch_state_t r_state;
    fetch_state_t w_state_nxt;
    logic [31:0]  r_pc_f;
    logic [31:0]  w_pc_f_nxt;
    logic [31:0]  r_req_addr;
    logic [31:0]  w_req_addr_nxt;
    logic [31:0]  r_skid_instr;
    logic [31:0]  r_skid_pc;
    logic         r_discard;
    logic         w_discard_nxt;
    logic         w_start;
    logic         w_deliver;
    logic         w_skid_cap;
    logic [31:0]  w_deliver_instr;
    logic [31:0]  w_deliver_pc;
    logic [31:0]  w_target;
    logic         w_ifid_bubble;
    logic         w_ifid_load;

    assign w_target = word_align(PC_Target_E);

    // Next-state, next-PC and delivery decisions. Redirect and flush both
    // override a stall: the FSM moves on and IF/ID takes a bubble.
    always_comb begin
        w_state_nxt     = r_state;
        w_pc_f_nxt      = r_pc_f;
        w_discard_nxt   = r_discard;
        w_start         = 1'b0;
        w_deliver       = 1'b0;
        w_skid_cap      = 1'b0;
        w_deliver_instr = IMEM_R_Data;
        w_deliver_pc    = r_req_addr;

        if (PC_Src_E) begin
            w_pc_f_nxt = w_target;
        end

        case (r_state)
            IDLE: begin
                w_start = 1'b1;
            end
            BUSY: begin
                if (IMEM_Ack) begin
                    if (!PC_Src_E) begin
                        w_pc_f_nxt = r_req_addr + 32'd4;
                    end
                    if (PC_Src_E || Flush_D || !Stall_D) begin
                        w_start   = 1'b1;
                        w_deliver = !PC_Src_E && !Flush_D;
                    end else begin
                        w_skid_cap  = 1'b1;
                        w_state_nxt = HOLD;
                    end
                end else if (PC_Src_E) begin
                    w_state_nxt   = DRAIN;
                    w_discard_nxt = 1'b1;
                end
            end
            HOLD: begin
                w_deliver_instr = r_skid_instr;
                w_deliver_pc    = r_skid_pc;
                if (PC_Src_E || Flush_D || !Stall_D) begin
                    w_start   = 1'b1;
                    w_deliver = !PC_Src_E && !Flush_D;
                end
            end
            DRAIN: begin
                if (IMEM_Ack) begin
                    w_start       = 1'b1;
                    w_discard_nxt = 1'b0;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase

        if (w_start) begin
            w_state_nxt = BUSY;
        end
        w_req_addr_nxt = w_start ? w_pc_f_nxt : r_req_addr;
    end

    // FSM, PC and request-address registers.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state    <= IDLE;
            r_pc_f     <= RESET_VECTOR;
            r_req_addr <= RESET_VECTOR;
            r_discard  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_pc_f     <= w_pc_f_nxt;
            r_req_addr <= w_req_addr_nxt;
            r_discard  <= w_discard_nxt;
        end
    end

    // Skid register catches an instruction that arrives while decode stalls.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_skid_instr <= INSTR_NOP;
            r_skid_pc    <= 32'd0;
        end else if (w_skid_cap) begin
            r_skid_instr <= IMEM_R_Data;
            r_skid_pc    <= r_req_addr;
        end
    end

    assign IMEM_Req  = (r_state == BUSY) || (r_state == DRAIN);
    assign IMEM_Addr = r_req_addr;

    assign w_ifid_bubble = PC_Src_E || Flush_D;
    assign w_ifid_load   = w_deliver && !r_discard;

    if_id_register u_if_id (
        .i_clk       (CLK),
        .i_rst       (RST),
        .i_bubble    (w_ifid_bubble),
        .i_hold      (Stall_D),
        .i_load      (w_ifid_load),
        .i_instr     (w_deliver_instr),
        .i_pc        (w_deliver_pc),
        .o_instr     (Instr_D),
        .o_pc        (PC_D),
        .o_pc_plus_4 (PC_Plus_4_D),
        .o_valid     (Valid_D)
    );

`ifdef FETCH_PERF_EN
    logic [31:0] r_fetch_count;
    logic [31:0] r_bubble_count;

    // Count valid loads and bubble loads into IF/ID; held cycles count neither.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_fetch_count  <= 32'd0;
            r_bubble_count <= 32'd0;
        end else if (w_ifid_bubble || (!Stall_D && !w_ifid_load)) begin
            r_bubble_count <= r_bubble_count + 32'd1;
        end else if (!Stall_D) begin
            r_fetch_count <= r_fetch_count + 32'd1;
        end
    end

    assign Fetch_Count  = r_fetch_count;
    assign Bubble_Count = r_bubble_count;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: a behavioural memory with selectable latency, a
// transaction-level model (fetch-address stream plus a queue of fetched
// but undelivered instructions) checked every cycle, and literal checks.
module tb_fetch_stage;

    localparam logic [31:0] RV  = 32'h0000_0000;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        CLK = 1'b0;
    logic        RST;
    logic        Stall_D;
    logic        Flush_D;
    logic        PC_Src_E;
    logic [31:0] PC_Target_E;
    logic        IMEM_Req;
    logic [31:0] IMEM_Addr;
    logic        IMEM_Ack = 1'b0;
    logic [31:0] IMEM_R_Data = 32'd0;
    logic [31:0] Instr_D;
    logic [31:0] PC_D;
    logic [31:0] PC_Plus_4_D;
    logic        Valid_D;
`ifdef FETCH_PERF_EN
    logic [31:0] Fetch_Count;
    logic [31:0] Bubble_Count;
`endif

    int checks   = 0;
    int failures = 0;

    fetch_stage dut (
        .CLK         (CLK),
        .RST         (RST),
        .Stall_D     (Stall_D),
        .Flush_D     (Flush_D),
        .PC_Src_E    (PC_Src_E),
        .PC_Target_E (PC_Target_E),
        .IMEM_Req    (IMEM_Req),
        .IMEM_Addr   (IMEM_Addr),
        .IMEM_Ack    (IMEM_Ack),
        .IMEM_R_Data (IMEM_R_Data),
        .Instr_D     (Instr_D),
        .PC_D        (PC_D),
        .PC_Plus_4_D (PC_Plus_4_D),
        .Valid_D     (Valid_D)
`ifdef FETCH_PERF_EN
        ,
        .Fetch_Count (Fetch_Count),
        .Bubble_Count(Bubble_Count)
`endif
    );

    // ---------------- clock ----------------
    always #5 CLK = ~CLK;

    // ---------------- helpers ----------------
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [15:0] h;
        h = a[31:16] ^ a[15:0];
        return {h, a[15:0]} ^ 32'h5A3C_0000;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #3;
    endtask

    // ---------------- memory driver ----------------
    int lat_mode = 0;  // 0: zero wait, 1: two wait cycles, 2: random 0..3
    int lat      = 0;
    int wcnt     = 0;
    bit in_txn   = 1'b0;
    bit done     = 1'b0;

    always @(negedge CLK) begin
        if (done || !IMEM_Req) in_txn = 1'b0;
        done = 1'b0;
        if (IMEM_Req) begin
            if (!in_txn) begin
                in_txn = 1'b1;
                wcnt   = 0;
                lat    = (lat_mode == 0) ? 0 : (lat_mode == 1) ? 2 : int'($urandom_range(0, 3));
            end else begin
                wcnt++;
            end
            IMEM_Ack    = (wcnt >= lat);
            IMEM_R_Data = IMEM_Ack ? mem_word(IMEM_Addr) : $urandom;
            done        = IMEM_Ack;
        end else begin
            IMEM_Ack    = 1'b0;
            IMEM_R_Data = $urandom;
        end
    end

    // ---------------- reference model + per-cycle compare ----------------
    logic [31:0] exp_q[$];     // PCs fetched but not yet handed to decode
    logic [31:0] exp_fetch;    // address the next fresh request must carry
    bit          stale;        // outstanding request belongs to the old path
    bit          idle;
    bit          started = 1'b0;
    logic [31:0] e_instr, e_pc, e_pc4;
    logic        e_valid, e_req;
    logic [31:0] e_fc, e_bc;
    bit          hs_chk, rst_chk;
    logic [31:0] hs_addr;
    logic        s_rst, s_req, s_ack, s_stall, s_flush, s_src;
    logic [31:0] s_addr, s_tgt;
    bit          inc;
    int          action;       // 0 hold, 1 load, 2 bubble
    logic [31:0] ld_pc;

    always begin : model
        @(posedge CLK);
        s_rst = RST;  s_req = IMEM_Req;  s_ack = IMEM_Ack;  s_addr = IMEM_Addr;
        s_stall = Stall_D;  s_flush = Flush_D;  s_src = PC_Src_E;  s_tgt = PC_Target_E;
        hs_chk  = 1'b0;
        rst_chk = 1'b0;
        if (s_rst) begin
            started = 1'b1;  idle = 1'b1;  stale = 1'b0;  exp_fetch = RV;
            exp_q.delete();
            e_instr = NOP;  e_valid = 1'b0;  e_pc = 32'd0;  e_pc4 = 32'd0;
            e_fc = 32'd0;  e_bc = 32'd0;
            rst_chk = 1'b1;
        end else if (started) begin
            inc = s_req && s_ack && !stale;
            if (s_src) exp_fetch = s_tgt & 32'hFFFF_FFFC;
            else if (inc) exp_fetch = s_addr + 32'd4;
            if (s_req && s_ack) stale = 1'b0;
            if (s_src && s_req && !s_ack) stale = 1'b1;
            hs_chk  = s_req && !s_ack;
            hs_addr = s_addr;
            action  = 2;
            if (s_src || s_flush) begin
                exp_q.delete();
            end else if (s_stall) begin
                action = 0;
                if (inc) exp_q.push_back(s_addr);
            end else if (exp_q.size() > 0) begin
                action = 1;
                ld_pc  = exp_q.pop_front();
            end else if (inc) begin
                action = 1;
                ld_pc  = s_addr;
            end
            if (action == 1) begin
                e_instr = mem_word(ld_pc);  e_valid = 1'b1;
                e_pc = ld_pc;  e_pc4 = ld_pc + 32'd4;  e_fc = e_fc + 32'd1;
            end else if (action == 2) begin
                e_instr = NOP;  e_valid = 1'b0;  e_bc = e_bc + 32'd1;
            end
            idle = 1'b0;
        end
        e_req = !idle && (exp_q.size() == 0);
        #1;
        if (started) begin
            check("imem_req", {31'd0, IMEM_Req}, {31'd0, e_req});
            if (IMEM_Req && !stale) check("imem_addr", IMEM_Addr, exp_fetch);
            if (hs_chk) check("addr_stable", IMEM_Addr, hs_addr);
            if (rst_chk) check("rst_addr", IMEM_Addr, RV);
            check("valid_d", {31'd0, Valid_D}, {31'd0, e_valid});
            check("instr_d", Instr_D, e_instr);
            check("pc_d", PC_D, e_pc);
            check("pc_plus_4_d", PC_Plus_4_D, e_pc4);
`ifdef FETCH_PERF_EN
            check("fetch_count", Fetch_Count, e_fc);
            check("bubble_count", Bubble_Count, e_bc);
`endif
        end
    end

    // ---------------- stimulus + literal checks ----------------
    initial begin
        RST = 1'b1;  Stall_D = 1'b0;  Flush_D = 1'b0;  PC_Src_E = 1'b0;  PC_Target_E = 32'd0;
        repeat (3) @(negedge CLK);
        check("lit_rst_req", {31'd0, IMEM_Req}, 32'd0);
        check("lit_rst_addr", IMEM_Addr, 32'h0000_0000);
        check("lit_rst_instr", Instr_D, 32'h0000_0013);
        check("lit_rst_valid", {31'd0, Valid_D}, 32'd0);
        check("lit_rst_pc", PC_D, 32'd0);
        check("lit_rst_pc4", PC_Plus_4_D, 32'd0);

        // zero-wait memory: one instruction per cycle
        RST = 1'b0;
        tick();
        check("lit_first_req", {31'd0, IMEM_Req}, 32'd1);
        check("lit_first_addr", IMEM_Addr, 32'h0000_0000);
        tick();
        check("lit_v0", {31'd0, Valid_D}, 32'd1);
        check("lit_pc0", PC_D, 32'h0000_0000);
        check("lit_i0", Instr_D, 32'h5A3C_0000);
        check("lit_pc4_0", PC_Plus_4_D, 32'h0000_0004);
        tick();
        check("lit_pc4", PC_D, 32'h0000_0004);
        check("lit_i4", Instr_D, 32'h5A38_0004);
        tick();
        check("lit_pc8", PC_D, 32'h0000_0008);
        check("lit_i8", Instr_D, 32'h5A34_0008);
        tick();
        check("lit_pc12", PC_D, 32'h0000_000C);
        check("lit_v12", {31'd0, Valid_D}, 32'd1);
        check("lit_addr16", IMEM_Addr, 32'h0000_0010);

        // flush together with stall gives a bubble
        @(negedge CLK);
        Stall_D = 1'b1;  Flush_D = 1'b1;
        tick();
        check("lit_flush_instr", Instr_D, 32'h0000_0013);
        check("lit_flush_valid", {31'd0, Valid_D}, 32'd0);
        @(negedge CLK);
        Stall_D = 1'b0;  Flush_D = 1'b0;

        // reset while a request is in flight
        lat_mode = 1;
        RST = 1'b1;
        tick();
        check("lit_mid_rst_req", {31'd0, IMEM_Req}, 32'd0);
        check("lit_mid_rst_instr", Instr_D, 32'h0000_0013);
        check("lit_mid_rst_valid", {31'd0, Valid_D}, 32'd0);
        check("lit_mid_rst_pc", PC_D, 32'd0);
`ifdef FETCH_PERF_EN
        check("lit_mid_rst_fc", Fetch_Count, 32'd0);
        check("lit_mid_rst_bc", Bubble_Count, 32'd0);
`endif
        @(negedge CLK);
        RST = 1'b0;
        tick();
        check("lit_restart_addr", IMEM_Addr, 32'h0000_0000);
        check("lit_restart_req", {31'd0, IMEM_Req}, 32'd1);

        // redirect while the request to 16 waits
        for (int i = 0; i < 60 && !(Valid_D && PC_D == 32'h0000_000C); i++) tick();
        check("wait_pc12", {31'd0, (Valid_D && PC_D == 32'h0000_000C)}, 32'd1);
        @(negedge CLK);
        PC_Src_E = 1'b1;  PC_Target_E = 32'h0000_0102;
        tick();
        check("lit_drain_req", {31'd0, IMEM_Req}, 32'd1);
        check("lit_drain_addr", IMEM_Addr, 32'h0000_0010);
        @(negedge CLK);
        PC_Src_E = 1'b0;
        for (int i = 0; i < 40 && !Valid_D; i++) tick();
        check("lit_target_pc", PC_D, 32'h0000_0100);
        check("lit_target_instr", Instr_D, 32'h5B3C_0100);

        // randomized traffic
        for (int blk = 0; blk < 4; blk++) begin
            lat_mode = (blk == 1) ? 0 : 2;
            repeat (800) begin
                @(negedge CLK);
                Stall_D  = ($urandom_range(0, 3) == 0);
                Flush_D  = ($urandom_range(0, 19) == 0);
                PC_Src_E = ($urandom_range(0, 11) == 0);
                PC_Target_E = ($urandom_range(0, 3) == 0) ?
                              (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
                RST = ($urandom_range(0, 299) == 0);
            end
        end
        @(negedge CLK);
        RST = 1'b0;  Stall_D = 1'b0;  Flush_D = 1'b0;  PC_Src_E = 1'b0;
        repeat (10) @(negedge CLK);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
